// File: rtl/subtotal_cpu_pkg.sv
// rtl/subtotal_cpu_pkg.sv - shared widths, opcodes and state encoding for subtotal_cpu
package subtotal_cpu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Opcodes whose execute cycle touches memory (read or write).
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_STO) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/subtotal_cpu_if.sv
// rtl/subtotal_cpu_if.sv - shared memory bus between subtotal_cpu and its word memory
interface subtotal_cpu_if
  import subtotal_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_address;
  logic              memrq;
  logic              rnw;

  modport master (
    input  in_data,
    output out_data,
    output out_address,
    output memrq,
    output rnw
  );

  modport slave (
    output in_data,
    input  out_data,
    input  out_address,
    input  memrq,
    input  rnw
  );

endinterface

// File: rtl/subtotal_cpu_alu.sv
// rtl/subtotal_cpu_alu.sv - accumulator datapath: load pass-through, add, subtract
module subtotal_cpu_alu
  import subtotal_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] result
);

  // Modulo-2^DATA_W arithmetic; no carry or flags are kept.
  always_comb begin
    result = acc;
    case (op)
      OP_LDA:  result = operand;
      OP_ADD:  result = acc + operand;
      OP_SUB:  result = acc - operand;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/subtotal_cpu.sv
// rtl/subtotal_cpu.sv - MU0-class accumulator CPU, fetch/execute; jumps enabled by SUBTOTAL_CPU_JUMP_EN
module subtotal_cpu
  import subtotal_cpu_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int RESET_PC = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  subtotal_cpu_if.master bus
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] alu_result;
  logic              jump_taken;

  logic              memrq_c;
  logic              rnw_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign opcode  = ir[DATA_W-1 -: 4];
  assign operand = ir[ADDR_W-1:0];

  subtotal_cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op      (opcode),
    .acc     (acc),
    .operand (bus.in_data),
    .result  (alu_result)
  );

  // Branch decision for the instruction currently in ir; without jumps 4-6 fall through as NOP.
  always_comb begin
    jump_taken = 1'b0;
`ifdef SUBTOTAL_CPU_JUMP_EN
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JGE:  jump_taken = ~acc[DATA_W-1];
      OP_JNE:  jump_taken = (acc != '0);
      default: jump_taken = 1'b0;
    endcase
`endif
  end

  // Bus drive decoded from state/ir/pc; gated by rst_n so an in-flight write dies with reset.
  always_comb begin
    memrq_c = 1'b0;
    rnw_c   = 1'b1;
    addr_c  = '0;
    wdata_c = '0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          memrq_c = 1'b1;
          addr_c  = pc;
        end
        EXEC: begin
          if (is_mem_op(opcode)) begin
            memrq_c = 1'b1;
            addr_c  = operand;
            if (opcode == OP_STO) begin
              rnw_c   = 1'b0;
              wdata_c = acc;
            end
          end
        end
        default: begin
          memrq_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.memrq       = memrq_c;
  assign bus.rnw         = rnw_c;
  assign bus.out_address = addr_c;
  assign bus.out_data    = wdata_c;

  // Fetch/execute sequencer: two cycles per instruction, HALT is terminal until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= ADDR_W'(RESET_PC);
      acc   <= '0;
      ir    <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= bus.in_data;
          pc    <= pc + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          if ((opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB)) begin
            acc <= alu_result;
          end
          if (jump_taken) begin
            pc <= operand;
          end
          state <= (opcode == OP_STP) ? HALT : FETCH;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtotal_cpu.sv
// tb/tb_subtotal_cpu.sv - directed and random programs against an instruction-level model
module tb_subtotal_cpu;
  import subtotal_cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  subtotal_cpu_if #(.DATA_W(16), .ADDR_W(12)) bus ();

  subtotal_cpu #(
    .DATA_W   (16),
    .ADDR_W   (12),
    .RESET_PC (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Word memory peer: 32 x 16, aliases above 31, combinational read, write on the edge.
  logic [15:0] mem [32];
  logic        load_en = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;

  assign bus.in_data = (bus.memrq && bus.rnw) ? mem[bus.out_address[4:0]] : 16'h0000;

  always @(posedge clk) begin
    if (load_en)
      mem[load_addr] <= load_data;
    else if (bus.memrq && !bus.rnw)
      mem[bus.out_address[4:0]] <= bus.out_data;
  end

  logic [15:0] img [32];
  logic [15:0] ref_mem [32];
  logic [15:0] m_acc;
  logic [11:0] m_pc;
  int          m_instrs;
  bit          m_halted;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-set interpreter: runs ref_mem from pc 0 until STP or a step limit.
  task automatic run_model();
    logic [11:0] p;
    logic [15:0] a;
    logic [15:0] ins;
    int          s;
    int          ea;
    p        = 12'd0;
    a        = 16'd0;
    s        = 0;
    m_halted = 1'b0;
    while (!m_halted && s < 500) begin
      ins = ref_mem[p % 32];
      p   = p + 12'd1;
      s++;
      ea  = int'(ins[11:0]) % 32;
      case (int'(ins[15:12]))
        0: a = ref_mem[ea];
        1: ref_mem[ea] = a;
        2: a = a + ref_mem[ea];
        3: a = a - ref_mem[ea];
`ifdef SUBTOTAL_CPU_JUMP_EN
        4: p = ins[11:0];
        5: if (int'(a) < 32768) p = ins[11:0];
        6: if (a != 16'd0) p = ins[11:0];
`endif
        7: m_halted = 1'b1;
        default: ;
      endcase
    end
    m_acc    = a;
    m_pc     = p;
    m_instrs = s;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 16'h0000;
  endtask

  // Called at a negedge while in reset; leaves the bench at a negedge.
  task automatic load_image();
    for (int i = 0; i < 32; i++) begin
      load_en   = 1'b1;
      load_addr = i[4:0];
      load_data = img[i];
      @(negedge clk);
    end
    load_en = 1'b0;
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  // Releases reset and checks the DUT finishes exactly where the model says.
  task automatic run_program(input string tag);
    bit ok;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];
    run_model();
    check({tag, "_model_halts"}, 32'(m_halted), 32'd1);
    rst_n = 1'b1;
    #1;
    check({tag, "_first_fetch_addr"}, 32'(bus.out_address), 32'd0);
    check({tag, "_first_fetch_rq"}, 32'(bus.memrq), 32'd1);
    if (m_halted) begin
      repeat (2 * m_instrs - 1) @(posedge clk);
      @(negedge clk);
      check({tag, "_not_halted_early"}, 32'(dut.state == HALT), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_halted"}, 32'(dut.state == HALT), 32'd1);
      check({tag, "_acc"}, 32'(dut.acc), 32'(m_acc));
      check({tag, "_pc"}, 32'(dut.pc), 32'(m_pc));
      check({tag, "_halt_memrq"}, 32'(bus.memrq), 32'd0);
      check({tag, "_halt_addr"}, 32'(bus.out_address), 32'd0);
      ok = 1'b1;
      for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) ok = 1'b0;
      check({tag, "_memory"}, 32'(ok), 32'd1);
    end
  endtask

  initial begin
    logic [3:0]  op;
    logic [11:0] opnd;
    int          len;
    int          r;

    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_memrq", 32'(bus.memrq), 32'd0);
      check("rst_rnw", 32'(bus.rnw), 32'd1);
      check("rst_addr", 32'(bus.out_address), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
    end
    check("rst_pc", 32'(dut.pc), 32'd0);
    check("rst_acc", 32'(dut.acc), 32'd0);
    check("rst_state", 32'(dut.state == FETCH), 32'd1);

    // Subtotal of six words.
    clear_img();
    img[0] = 16'h0015;
    for (int i = 1; i <= 5; i++) img[i] = 16'h2015 + 16'(i);
    img[6] = 16'h7000;
    for (int i = 0; i < 6; i++) img[21 + i] = 16'(10 + i);
    load_image();
    run_program("subtotal");
    check("subtotal_acc_75", 32'(dut.acc), 32'h004B);
    check("subtotal_pc_7", 32'(dut.pc), 32'd7);

    // Store, with reset landing in the middle of the STO execute cycle.
    start_reset();
    clear_img();
    img[0]  = 16'h0015;
    img[1]  = 16'h101E;
    img[2]  = 16'h7000;
    img[21] = 16'h000A;
    img[30] = 16'h1234;
    load_image();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sto_state_exec", 32'(dut.state == EXEC), 32'd1);
    check("sto_memrq", 32'(bus.memrq), 32'd1);
    check("sto_rnw", 32'(bus.rnw), 32'd0);
    check("sto_addr", 32'(bus.out_address), 32'd30);
    check("sto_data", 32'(bus.out_data), 32'h000A);
    #1 rst_n = 1'b0;
    #1;
    check("abort_memrq", 32'(bus.memrq), 32'd0);
    check("abort_rnw", 32'(bus.rnw), 32'd1);
    check("abort_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_word_kept", 32'(mem[30]), 32'h1234);
    run_program("sto");
    check("sto_word_written", 32'(mem[30]), 32'h000A);

    // Subtract wrap and conditional jumps on a negative accumulator.
    start_reset();
    clear_img();
    img[0]  = 16'h3014;
    img[1]  = 16'h5005;
    img[2]  = 16'h6006;
    img[3]  = 16'h7000;
    img[5]  = 16'h7000;
    img[6]  = 16'h7000;
    img[20] = 16'h0001;
    load_image();
    run_program("subwrap");
    check("subwrap_acc", 32'(dut.acc), 32'h0000FFFF);
`ifdef SUBTOTAL_CPU_JUMP_EN
    check("subwrap_jne_taken_pc", 32'(dut.pc), 32'd7);
`else
    check("subwrap_nojump_pc", 32'(dut.pc), 32'd4);
`endif

    // Unconditional jump back to 0.
    start_reset();
    clear_img();
    img[0]  = 16'h0015;
    img[1]  = 16'h4000;
    img[2]  = 16'h7000;
    img[21] = 16'h0003;
    load_image();
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
`ifdef SUBTOTAL_CPU_JUMP_EN
    check("jmp_pc", 32'(dut.pc), 32'd0);
`else
    check("jmp_nop_pc", 32'(dut.pc), 32'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("jmp_nop_then_halt", 32'(dut.state == HALT), 32'd1);
`endif

    // Random straight-line programs over the data area 16..31 with aliased operands.
    for (int t = 0; t < 8; t++) begin
      start_reset();
      clear_img();
      len = $urandom_range(3, 12);
      for (int k = 0; k < len; k++) begin
        r    = $urandom_range(0, 11);
        op   = 4'((r < 4) ? r : r + 4);
        opnd = {7'($urandom), 1'b1, 4'($urandom)};
        img[k] = {op, opnd};
      end
      img[len] = {4'h7, 12'($urandom)};
      for (int i = 16; i < 32; i++) img[i] = 16'($urandom);
      load_image();
      run_program($sformatf("rand%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
